// File: rtl/entropy_scan_controller.sv
// Buffers NUM_BLOCKS quantized 8x8 blocks, then emits DCs and progressive-scan (run, level) AC pairs.
// Outputs are registered; a pending DC/AC output holds until out_ready and freezes the scan iterator.
module entropy_scan_controller #(
  parameter int NUM_BLOCKS = 4,
  parameter int COEFF_W    = 20
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [COEFF_W-1:0] in_coeff [8][8],
  input  logic                      out_ready,
  output logic                      dc_valid,
  output logic [31:0]               dc_coeff,
  output logic                      ac_valid,
  output logic [8:0]                ac_run,
  output logic [31:0]               ac_abs_level,
  output logic                      ac_sign,
  output logic                      slice_done,
  output logic                      busy
);

  localparam int BW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam logic [BW-1:0] LAST_BLK = BW'(NUM_BLOCKS - 1);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_DC   = 2'd1;
  localparam logic [1:0] S_AC   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [5:0] SCAN [64] = '{
    6'd0,  6'd1,  6'd8,  6'd9,  6'd2,  6'd3,  6'd10, 6'd11,
    6'd16, 6'd17, 6'd24, 6'd25, 6'd18, 6'd19, 6'd26, 6'd27,
    6'd4,  6'd5,  6'd12, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14,
    6'd21, 6'd28, 6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd31,
    6'd32, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34, 6'd35, 6'd42,
    6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36, 6'd37, 6'd44,
    6'd51, 6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] blk_cnt_q, blk_cnt_d;
  logic [5:0]    pos_q, pos_d;
  logic [8:0]    run_q, run_d;
  logic          dc_valid_q, dc_valid_d;
  logic [31:0]   dc_coeff_q, dc_coeff_d;
  logic          ac_valid_q, ac_valid_d;
  logic [8:0]    ac_run_q, ac_run_d;
  logic [31:0]   ac_abs_q, ac_abs_d;
  logic          ac_sign_q, ac_sign_d;
  logic          slice_done_q, slice_done_d;

  logic signed [COEFF_W-1:0] buf_q [NUM_BLOCKS][64];

  logic                      accept;
  logic                      advance;
  logic signed [COEFF_W-1:0] cur_coeff;
  logic signed [32:0]        cur_ext;
  logic [31:0]               cur_mag;
  logic [BW-1:0]             dc_idx;
  logic signed [COEFF_W-1:0] dc_src;
  logic [31:0]               dc_ext;

  assign in_ready = (state_q == S_LOAD) && reset_n;
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != S_LOAD);

  assign cur_coeff = buf_q[blk_cnt_q][SCAN[pos_q]];
  assign cur_ext   = {{(33-COEFF_W){cur_coeff[COEFF_W-1]}}, cur_coeff};
  // Magnitude taken in 32 bits so the most-negative input still fits.
  assign cur_mag   = cur_ext[32] ? (~cur_ext[31:0] + 32'd1) : cur_ext[31:0];

  // While a DC is pending, look ahead to the next block so the transfer cycle reloads directly.
  assign dc_idx = dc_valid_q ? blk_cnt_q + 1'b1 : blk_cnt_q;
  assign dc_src = buf_q[dc_idx][0];
  assign dc_ext = {{(32-COEFF_W){dc_src[COEFF_W-1]}}, dc_src};

  always_comb begin
    state_d      = state_q;
    blk_cnt_d    = blk_cnt_q;
    pos_d        = pos_q;
    run_d        = run_q;
    dc_valid_d   = dc_valid_q;
    dc_coeff_d   = dc_coeff_q;
    ac_valid_d   = ac_valid_q;
    ac_run_d     = ac_run_q;
    ac_abs_d     = ac_abs_q;
    ac_sign_d    = ac_sign_q;
    slice_done_d = 1'b0;
    advance      = 1'b0;

    case (state_q)
      S_LOAD: begin
        if (accept) begin
          if (blk_cnt_q == LAST_BLK) begin
            blk_cnt_d = '0;
            state_d   = S_DC;
          end else begin
            blk_cnt_d = blk_cnt_q + 1'b1;
          end
        end
      end
      S_DC: begin
        if (!dc_valid_q) begin
          dc_valid_d = 1'b1;
          dc_coeff_d = dc_ext;
        end else if (out_ready) begin
          if (blk_cnt_q == LAST_BLK) begin
            dc_valid_d = 1'b0;
            blk_cnt_d  = '0;
            pos_d      = 6'd1;
            run_d      = '0;
            state_d    = S_AC;
          end else begin
            blk_cnt_d  = blk_cnt_q + 1'b1;
            dc_coeff_d = dc_ext;
          end
        end
      end
      S_AC: begin
        if (ac_valid_q) begin
          if (out_ready) begin
            ac_valid_d = 1'b0;
            advance    = 1'b1;
          end
        end else if (cur_coeff == '0) begin
          run_d   = run_q + 9'd1;
          advance = 1'b1;
        end else begin
          ac_valid_d = 1'b1;
          ac_run_d   = run_q;
          ac_abs_d   = cur_mag;
          ac_sign_d  = cur_ext[32];
          run_d      = '0;
        end
      end
      S_DONE: state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase

    // Block index is the inner loop, scan position the outer loop.
    if (advance) begin
      if (blk_cnt_q == LAST_BLK) begin
        blk_cnt_d = '0;
        if (pos_q == 6'd63) begin
          state_d      = S_DONE;
          slice_done_d = 1'b1;
        end else begin
          pos_d = pos_q + 6'd1;
        end
      end else begin
        blk_cnt_d = blk_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_LOAD;
      blk_cnt_q    <= '0;
      pos_q        <= '0;
      run_q        <= '0;
      dc_valid_q   <= 1'b0;
      dc_coeff_q   <= '0;
      ac_valid_q   <= 1'b0;
      ac_run_q     <= '0;
      ac_abs_q     <= '0;
      ac_sign_q    <= 1'b0;
      slice_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      blk_cnt_q    <= blk_cnt_d;
      pos_q        <= pos_d;
      run_q        <= run_d;
      dc_valid_q   <= dc_valid_d;
      dc_coeff_q   <= dc_coeff_d;
      ac_valid_q   <= ac_valid_d;
      ac_run_q     <= ac_run_d;
      ac_abs_q     <= ac_abs_d;
      ac_sign_q    <= ac_sign_d;
      slice_done_q <= slice_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          buf_q[blk_cnt_q][6'(r*8 + c)] <= in_coeff[r][c];
        end
      end
    end
  end

  assign dc_valid     = dc_valid_q;
  assign dc_coeff     = dc_coeff_q;
  assign ac_valid     = ac_valid_q;
  assign ac_run       = ac_run_q;
  assign ac_abs_level = ac_abs_q;
  assign ac_sign      = ac_sign_q;
  assign slice_done   = slice_done_q;

endmodule

// File: tb/tb_entropy_scan_controller.sv
// Randomized and directed slices checked against a scan-order reference model.
module tb_entropy_scan_controller;

  localparam int NB = 4;
  localparam int CW = 20;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [CW-1:0] in_coeff [8][8];
  logic                 out_ready;
  logic                 dc_valid;
  logic [31:0]          dc_coeff;
  logic                 ac_valid;
  logic [8:0]           ac_run;
  logic [31:0]          ac_abs_level;
  logic                 ac_sign;
  logic                 slice_done;
  logic                 busy;

  always #5 clk = ~clk;

  entropy_scan_controller #(.NUM_BLOCKS(NB), .COEFF_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_coeff(in_coeff), .out_ready(out_ready), .dc_valid(dc_valid), .dc_coeff(dc_coeff),
    .ac_valid(ac_valid), .ac_run(ac_run), .ac_abs_level(ac_abs_level), .ac_sign(ac_sign),
    .slice_done(slice_done), .busy(busy)
  );

  int scan_tbl [64] = '{
    0, 1, 8, 9, 2, 3, 10, 11, 16, 17, 24, 25, 18, 19, 26, 27,
    4, 5, 12, 20, 13, 6, 7, 14, 21, 28, 29, 22, 15, 23, 30, 31,
    32, 33, 40, 48, 41, 34, 35, 42, 49, 56, 57, 50, 43, 36, 37, 44,
    51, 58, 59, 52, 45, 38, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  int n_tests = 0;
  int n_fail  = 0;

  int          blk_data [NB][64];
  logic [31:0] exp_dc[$], obs_dc[$];
  logic [41:0] exp_ac[$], obs_ac[$];

  int          rdy_mode = 0;
  int          stall_cnt = 0;
  int          sd_cnt, dc_seen, ac_cycles, overlap_cnt, rdy_busy_cnt;
  bit          ac_pend, dc_pend;
  logic [41:0] ac_pend_val;
  logic [31:0] dc_pend_val;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: walk positions outer, blocks inner, counting zeros between levels.
  task automatic build_model();
    int run;
    int v;
    longint av;
    exp_dc.delete();
    exp_ac.delete();
    for (int b = 0; b < NB; b++) exp_dc.push_back(32'(blk_data[b][0]));
    run = 0;
    for (int p = 1; p < 64; p++) begin
      for (int b = 0; b < NB; b++) begin
        v = blk_data[b][scan_tbl[p]];
        if (v == 0) begin
          run++;
        end else begin
          av = (v < 0) ? -longint'(v) : longint'(v);
          exp_ac.push_back({9'(run), 32'(av), (v < 0) ? 1'b1 : 1'b0});
          run = 0;
        end
      end
    end
  endtask

  task automatic clear_data();
    for (int b = 0; b < NB; b++)
      for (int n = 0; n < 64; n++) blk_data[b][n] = 0;
  endtask

  task automatic fill_random(input int pct);
    int v;
    for (int b = 0; b < NB; b++) begin
      for (int n = 0; n < 64; n++) begin
        v = 0;
        if ($urandom_range(0, 99) < pct) begin
          if ($urandom_range(0, 7) == 0) v = $urandom_range(0, 1) ? -524288 : 524287;
          else begin
            v = int'($urandom_range(1, 600));
            if ($urandom_range(0, 1) == 1) v = -v;
          end
        end
        blk_data[b][n] = v;
      end
    end
  endtask

  task automatic drive_block(input int b);
    for (int n = 0; n < 64; n++) in_coeff[n/8][n%8] = CW'(blk_data[b][n]);
  endtask

  task automatic drive_junk();
    for (int n = 0; n < 64; n++) in_coeff[n/8][n%8] = CW'($urandom);
  endtask

  task automatic load_blocks(input string tag);
    int t;
    sd_cnt = 0; dc_seen = 0; ac_cycles = 0; overlap_cnt = 0; rdy_busy_cnt = 0;
    obs_dc.delete();
    obs_ac.delete();
    for (int b = 0; b < NB; b++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      drive_block(b);
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
      chk({tag, ":in_ready"}, in_ready, 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic run_slice(input string tag, input int mode, input bit junk, input bit chk_cycles);
    int t;
    build_model();
    rdy_mode = mode;
    load_blocks(tag);
    if (junk) drive_junk();
    in_valid = junk;
    t = 0;
    while (!slice_done && t < 4000) begin @(posedge clk); #1; t++; end
    in_valid = 1'b0;
    chk({tag, ":done_seen"}, slice_done, 1);
    @(posedge clk); #1;
    chk({tag, ":done_pulse"}, slice_done, 0);
    chk({tag, ":idle_busy"}, busy, 0);
    chk({tag, ":idle_rdy"}, in_ready, 1);
    chk({tag, ":done_cnt"}, sd_cnt, 1);
    chk({tag, ":overlap"}, overlap_cnt, 0);
    chk({tag, ":rdy_busy"}, rdy_busy_cnt, 0);
    chk({tag, ":dc_cnt"}, obs_dc.size(), exp_dc.size());
    for (int i = 0; i < exp_dc.size() && i < obs_dc.size(); i++) chk({tag, ":dc"}, obs_dc[i], exp_dc[i]);
    chk({tag, ":ac_cnt"}, obs_ac.size(), exp_ac.size());
    for (int i = 0; i < exp_ac.size() && i < obs_ac.size(); i++) chk({tag, ":ac"}, obs_ac[i], exp_ac[i]);
    if (chk_cycles) chk({tag, ":ac_cycles"}, ac_cycles, 63*NB + exp_ac.size());
  endtask

  // Downstream ready: 0 always high, 1 random, 2 stall each new AC level for five cycles.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (ac_valid && stall_cnt < 5) begin
            out_ready = 1'b0;
            stall_cnt++;
          end else begin
            out_ready = 1'b1;
            if (ac_valid) stall_cnt = 0;
          end
        end
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        ac_pend = 1'b0;
        dc_pend = 1'b0;
      end else begin
        if (ac_pend) chk("ac_hold", {ac_valid, ac_run, ac_abs_level, ac_sign}, {1'b1, ac_pend_val});
        if (dc_pend) chk("dc_hold", {dc_valid, dc_coeff}, {1'b1, dc_pend_val});
        ac_pend     = ac_valid && !out_ready;
        ac_pend_val = {ac_run, ac_abs_level, ac_sign};
        dc_pend     = dc_valid && !out_ready;
        dc_pend_val = dc_coeff;
        if (dc_valid && ac_valid) overlap_cnt++;
        if (busy && in_ready) rdy_busy_cnt++;
        if (busy && dc_seen == NB && !slice_done) ac_cycles++;
        if (dc_valid && out_ready) begin
          obs_dc.push_back(dc_coeff);
          dc_seen++;
        end
        if (ac_valid && out_ready) obs_ac.push_back({ac_run, ac_abs_level, ac_sign});
        if (slice_done) sd_cnt++;
      end
    end
  end

  initial begin
    int t;
    int pcts [6] = '{5, 30, 2, 0, 15, 50};
    reset_n  = 1'b0;
    in_valid = 1'b0;
    clear_data();
    for (int b = 0; b < 1; b++) drive_block(b);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_dc_valid", dc_valid, 0);
    chk("rst_ac_valid", ac_valid, 0);
    chk("rst_done", slice_done, 0);
    chk("rst_dc_coeff", dc_coeff, 0);
    chk("rst_ac_abs", ac_abs_level, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    chk("post_rst_rdy", in_ready, 1);
    chk("post_rst_busy", busy, 0);

    clear_data();
    blk_data[0][0] = 5; blk_data[1][0] = -3; blk_data[2][0] = 0; blk_data[3][0] = 7;
    run_slice("dc_only", 0, 1'b1, 1'b1);
    if (obs_dc.size() > 1) chk("dc_neg3", obs_dc[1], 32'hFFFFFFFD);

    clear_data();
    blk_data[0][1] = 2; blk_data[1][8] = -1;
    run_slice("two_levels", 1, 1'b0, 1'b0);

    clear_data();
    blk_data[3][63] = 1;
    run_slice("last_coeff", 0, 1'b0, 1'b1);
    if (obs_ac.size() > 0) chk("run251", obs_ac[0][41:33], 251);

    clear_data();
    blk_data[0][1] = 9; blk_data[2][10] = -4; blk_data[3][62] = 100; blk_data[1][63] = -7;
    stall_cnt = 0;
    run_slice("stall5", 2, 1'b0, 1'b0);

    clear_data();
    blk_data[0][1] = -524288;
    run_slice("most_neg", 0, 1'b0, 1'b1);
    if (obs_ac.size() > 0) chk("most_neg_abs", obs_ac[0][32:1], 524288);
    if (obs_ac.size() > 0) chk("most_neg_sign", obs_ac[0][0], 1);

    for (int i = 0; i < 6; i++) begin
      fill_random(pcts[i]);
      run_slice("rnd", i % 3, (i % 2) == 0, (i % 3) == 0);
    end

    // Abort a slice while an AC level is being presented.
    fill_random(40);
    rdy_mode = 0;
    load_blocks("abort");
    in_valid = 1'b0;
    t = 0;
    while (!ac_valid && t < 2000) begin @(posedge clk); #1; t++; end
    chk("abort_ac_seen", ac_valid, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_ac_valid", ac_valid, 0);
    chk("abort_ac_abs", ac_abs_level, 0);
    chk("abort_ac_run", ac_run, 0);
    chk("abort_ac_sign", ac_sign, 0);
    chk("abort_dc_valid", dc_valid, 0);
    chk("abort_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    chk("abort_rdy", in_ready, 1);
    clear_data();
    blk_data[0][0] = 5; blk_data[1][0] = -3; blk_data[2][0] = 0; blk_data[3][0] = 7;
    run_slice("after_abort", 1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
